// File: rtl/debounce_fsm_if.sv
// Signal bundle between the debounce control FSM and its environment:
// raw input, settle-counter handshake, clean level, pulses and diagnostics.
interface debounce_fsm_if #(
    parameter int BW = 8
);
    logic          din;
    logic          tick_done;
    logic          cnt_sclr;
    logic          cnt_en;
    logic          dout;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [BW-1:0] bounce_cnt;

    modport master (
        output din,
        output tick_done,
        input  cnt_sclr,
        input  cnt_en,
        input  dout,
        input  rise_pulse,
        input  fall_pulse,
        input  bounce_cnt
    );

    modport slave (
        input  din,
        input  tick_done,
        output cnt_sclr,
        output cnt_en,
        output dout,
        output rise_pulse,
        output fall_pulse,
        output bounce_cnt
    );
endinterface

// File: rtl/debounce_fsm.sv
// Debounce control stage: synchronises din, runs the settle counter and
// publishes a clean level with rise/fall strobes and an abort counter.
module debounce_fsm #(
    parameter int SYNC_STAGES = 2,
    parameter bit INIT_LEVEL  = 1'b0,
    parameter int BW          = 8
) (
    input logic           clk,
    input logic           rst,
    debounce_fsm_if.slave bus
);
    typedef enum logic [1:0] {
        S_LO,
        S_WAIT_HI,
        S_HI,
        S_WAIT_LO
    } state_t;

    localparam state_t S_RST = INIT_LEVEL ? S_HI : S_LO;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic                   r_sclr;
    logic                   r_en;
    logic                   r_dout;
    logic                   r_rise;
    logic                   r_fall;
    logic [BW-1:0]          r_bcnt;

    logic   w_s_in;
    state_t w_nxt;
    logic   w_abort;
    logic   w_rise;
    logic   w_fall;

    assign w_s_in = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.din};
        end
    end

    // A reversal of s_in outranks tick_done in the same cycle.
    always_comb begin
        w_nxt   = r_state;
        w_abort = 1'b0;
        w_rise  = 1'b0;
        w_fall  = 1'b0;
        unique case (r_state)
            S_LO: begin
                if (w_s_in) w_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (!w_s_in) begin
                    w_nxt   = S_LO;
                    w_abort = 1'b1;
                end else if (bus.tick_done) begin
                    w_nxt  = S_HI;
                    w_rise = 1'b1;
                end
            end
            S_HI: begin
                if (!w_s_in) w_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (w_s_in) begin
                    w_nxt   = S_HI;
                    w_abort = 1'b1;
                end else if (bus.tick_done) begin
                    w_nxt  = S_LO;
                    w_fall = 1'b1;
                end
            end
            default: w_nxt = S_RST;
        endcase
    end

    // Outputs are decoded from the next state so they track r_state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RST;
            r_sclr  <= 1'b1;
            r_en    <= 1'b0;
            r_dout  <= INIT_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_nxt;
            r_sclr  <= (w_nxt == S_LO) || (w_nxt == S_HI);
            r_en    <= (w_nxt == S_WAIT_HI) || (w_nxt == S_WAIT_LO);
            r_dout  <= (w_nxt == S_HI) || (w_nxt == S_WAIT_LO);
            r_rise  <= w_rise;
            r_fall  <= w_fall;
            if (w_abort && (r_bcnt != {BW{1'b1}})) begin
                r_bcnt <= r_bcnt + BW'(1);
            end
        end
    end

    assign bus.cnt_sclr   = r_sclr;
    assign bus.cnt_en     = r_en;
    assign bus.dout       = r_dout;
    assign bus.rise_pulse = r_rise;
    assign bus.fall_pulse = r_fall;
    assign bus.bounce_cnt = r_bcnt;
endmodule

// File: doc/debounce_fsm.md
# debounce_fsm

Control stage of the debounce circuit. Synchronises a raw bouncy input, drives the settle counter's synchronous clear and enable, and consumes the counter's terminal bit. It publishes a clean level plus one-cycle rise/fall pulses. A saturating count of aborted settle attempts is kept for diagnostics.

## Interface

**Parameters**
- `SYNC_STAGES`, default 2: flip-flops in the `din` synchroniser chain, at least 2.
- `INIT_LEVEL`, default 0: debounced level assumed at reset.
- `BW`, default 8: width of `bounce_cnt`.

**Ports**
- `clk` input, 1: single clock; all state changes on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `din` input, 1: raw asynchronous switch/button level.
- `tick_done` input, 1: settle counter terminal bit (counter MSB).
- `cnt_sclr` output, 1: synchronous clear to the settle counter.
- `cnt_en` output, 1: count enable to the settle counter.
- `dout` output, 1: debounced level.
- `rise_pulse` output, 1: one-cycle strobe on a 0→1 `dout` change.
- `fall_pulse` output, 1: one-cycle strobe on a 1→0 `dout` change.
- `bounce_cnt` output, BW: saturating count of aborted settle windows.

## Operation

**Synchroniser**
- `din` passes through `SYNC_STAGES` flops. The last stage is `s_in`.
- All flops reset to `INIT_LEVEL`.

**FSM states:** S_LO, S_WAIT_HI, S_HI, S_WAIT_LO.
- Reset state is S_HI if `INIT_LEVEL` is 1, otherwise S_LO.

**Transitions**
- S_LO: if `s_in` is 1, go to S_WAIT_HI.
- S_WAIT_HI:
  - If `s_in` is 0, go to S_LO and increment `bounce_cnt`.
  - Else if `tick_done` is 1, go to S_HI and fire `rise_pulse`.
  - A bounce (`s_in` dropping) has priority over `tick_done` in the same cycle.
- S_HI: if `s_in` is 0, go to S_WAIT_LO.
- S_WAIT_LO: mirror of S_WAIT_HI.
  - `s_in` returning to 1 goes to S_HI and increments `bounce_cnt`.
  - Otherwise `tick_done` goes to S_LO and fires `fall_pulse`.

**Outputs**
- Counter controls are Moore, decoded from the state register:
  - `cnt_sclr` = 1 in S_LO and S_HI, 0 in the WAIT states.
  - `cnt_en` = 1 in the WAIT states only.
  - `cnt_sclr` and `cnt_en` are never both 1.
- `dout` = 1 in S_HI and S_WAIT_LO. It changes only on a completed settle.
- `rise_pulse` and `fall_pulse` are registered.
  - Each is high for exactly the first cycle after its settling transition, then 0.
  - They are never high together.
- `bounce_cnt` is a BW-bit unsigned counter. It saturates at 2^BW−1 with no wrap and is cleared only by `rst`.

**Reset**
- Applies on any edge where `rst` = 1, including mid-settle.
- Values: state per `INIT_LEVEL`, synchroniser = `INIT_LEVEL`, `dout` = `INIT_LEVEL`, `cnt_sclr` = 1, `cnt_en` = 0, both pulses 0, `bounce_cnt` = 0.
- An in-progress settle is abandoned with no pulse and no bounce increment.

## Timing

**Settle window**
- The counter is held cleared in a stable state, so it is 0 on the first WAIT cycle.
- With a counter of width N, `tick_done` rises after 2^(N−1) enabled cycles.
- The FSM leaves WAIT on the following edge.

**Latency**
- Edge 1 is the first rising edge that samples the new `din` level.
- `dout` changes, and the pulse asserts, after edge `SYNC_STAGES` + 2^(N−1) + 2.
- Examples: 1028 edges for N=11; 12 edges for N=4 with `SYNC_STAGES`=2.

**Glitch rejection**
- A `din` pulse narrower than `SYNC_STAGES` cycles may be filtered entirely.
- Any `s_in` reversal inside the window restarts settling. The counter is cleared the cycle after the abort.

**Other rules**
- `tick_done` is ignored in S_LO and S_HI.
- Minimum spacing between consecutive pulses is 2^(N−1) + 2 cycles.

## Test plan

Bench setup: N=4 settle counter, `SYNC_STAGES`=2, BW=8, `INIT_LEVEL`=0.

1. **Reset values:** hold `rst` for 3 cycles with `din`=1. Require `dout`=0, `cnt_sclr`=1, `cnt_en`=0, pulses 0, `bounce_cnt`=0.
2. **Clean rise:** `din` steps 0→1 and holds. Require `dout`=1 and `rise_pulse`=1 after edge 12, with `rise_pulse`=0 on edge 13. Require `cnt_en`=1 for exactly 9 cycles.
3. **Bounce:** toggle `din` 1,0,1,0,1 with 5-cycle periods, then hold 1. Require `bounce_cnt`=2 and no `rise_pulse` before the final settle. Require exactly one `rise_pulse` after the hold.
4. **Clean fall from high:** require a single `fall_pulse` 12 edges after the `din` 1→0 step, and `rise_pulse` stays 0.
5. **Reset mid-settle:** assert `rst` on the 5th WAIT cycle. Require an immediate return to the reset values, no pulse, and `bounce_cnt`=0.
6. **Saturation:** force 300 aborted windows, then a further 10. Require `bounce_cnt` holds at 255 with no wrap.
